// File: rtl/pattern_detector_param_if.sv
// -----------------------------------------------------------------------------
// pattern_detector_param_if
//
// Purpose: groups the data, configuration and result signals of the serial
// pattern detector into one bundle. clk and rst are not part of it; they stay
// plain ports on the detector.
//
// Signals:
//   in           master->slave  serial data bit
//   valid        master->slave  qualifies in
//   overlap      master->slave  1 = overlapping detection, 0 = non-overlapping
//   cfg_load     master->slave  load strobe for cfg_pattern
//   cfg_pattern  master->slave  new pattern, MSB is the first bit of the sequence
//   cnt_clr      master->slave  synchronous clear of match_count
//   out          slave->master  registered single-cycle match pulse
//   match_count  slave->master  saturating match counter
//   cur_pattern  slave->master  currently active pattern
// -----------------------------------------------------------------------------
interface pattern_detector_param_if #(
   parameter int PAT_LEN = 5,
   parameter int CNT_W   = 8
);
   logic               in;
   logic               valid;
   logic               overlap;
   logic               cfg_load;
   logic [PAT_LEN-1:0] cfg_pattern;
   logic               cnt_clr;
   logic               out;
   logic [CNT_W-1:0]   match_count;
   logic [PAT_LEN-1:0] cur_pattern;

   // Stimulus side (bench or upstream logic).
   modport master (
      output in,
      output valid,
      output overlap,
      output cfg_load,
      output cfg_pattern,
      output cnt_clr,
      input  out,
      input  match_count,
      input  cur_pattern
   );

   // Detector side.
   modport slave (
      input  in,
      input  valid,
      input  overlap,
      input  cfg_load,
      input  cfg_pattern,
      input  cnt_clr,
      output out,
      output match_count,
      output cur_pattern
   );
endinterface

// File: rtl/pattern_detector_param.sv
// -----------------------------------------------------------------------------
// pattern_detector_param
//
// Purpose: serial bit-pattern detector with a run-time loadable pattern,
// selectable overlapping / non-overlapping detection and a saturating match
// counter.
//
// Parameters:
//   PAT_LEN   pattern length in bits (2..16)
//   PAT_INIT  pattern loaded at reset
//   CNT_W     width of the match counter
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   pattern_detector_param_if slave modport (data, config, results)
//
// Operation: each accepted bit (valid=1, cfg_load=0) is shifted into a history
// register, newest bit at the LSB. Once at least PAT_LEN bits have been
// accepted since the last flush, the shifted window is compared with the
// active pattern; a match produces a one-cycle pulse on out one edge later.
// -----------------------------------------------------------------------------
module pattern_detector_param #(
   parameter int                 PAT_LEN  = 5,
   parameter logic [PAT_LEN-1:0] PAT_INIT = 5'b01101,
   parameter int                 CNT_W    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   pattern_detector_param_if.slave   bus
);

   // fill counts 0..PAT_LEN inclusive.
   localparam int                FILL_W    = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
   // With this many bits already held, the incoming bit completes a window.
   localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   logic [PAT_LEN-1:0] hist_q;
   logic [PAT_LEN-1:0] hist_d;
   logic [PAT_LEN-1:0] pat_q;
   logic [PAT_LEN-1:0] pat_d;
   logic [FILL_W-1:0]  fill_q;
   logic [FILL_W-1:0]  fill_d;
   logic               out_q;
   logic               out_d;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_d;

   logic               accept;
   logic [PAT_LEN-1:0] window;
   logic [PAT_LEN-1:0] eq_bits;
   logic               window_eq;
   logic               fill_armed;
   logic               hit;

   // A configuration load takes priority and swallows any sample offered in
   // the same cycle.
   assign accept = bus.valid & ~bus.cfg_load;

   // Window as it would look after shifting in the current bit.
   assign window = {hist_q[PAT_LEN-2:0], bus.in};

   // Bitwise equality against the active pattern.
   generate
      for (genvar gi = 0; gi < PAT_LEN; gi++) begin : g_cmp
         assign eq_bits[gi] = ~(window[gi] ^ pat_q[gi]);
      end
   endgenerate

   assign window_eq  = &eq_bits;
   assign fill_armed = (fill_q >= FILL_ARM);
   assign hit        = accept & window_eq & fill_armed;

   always_comb begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      pat_d   = pat_q;
      out_d   = 1'b0;
      count_d = count_q;

      if (bus.cfg_load) begin
         // New pattern: any partially collected window is meaningless now.
         pat_d  = bus.cfg_pattern;
         hist_d = '0;
         fill_d = '0;
      end else if (accept) begin
         hist_d = window;
         out_d  = hit;
         if (hit && !bus.overlap) begin
            // Non-overlapping: none of the matched bits may start a new match.
            fill_d = '0;
         end else if (fill_q != FILL_FULL) begin
            fill_d = fill_q + FILL_W'(1);
         end
      end

      // Clear wins over the old value but a same-cycle match still counts.
      if (bus.cnt_clr) begin
         count_d = hit ? CNT_W'(1) : '0;
      end else if (hit && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= PAT_INIT;
         out_q   <= 1'b0;
         count_q <= '0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         out_q   <= out_d;
         count_q <= count_d;
      end
   end

   assign bus.out         = out_q;
   assign bus.match_count = count_q;
   assign bus.cur_pattern = pat_q;

endmodule
